mc_main_ctrl: RTL and testbench

//  Multicycle main-control FSM for the MIPS-subset core. Sequences the shared ALU, memory port, IR, PC and

---
 rtl/mc_main_ctrl_pkg.sv | 61 ++++++
 rtl/mc_wait_timer.sv | 31 +++
 rtl/mc_main_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_main_ctrl_pkg.sv
// Shared encodings for the multicycle main controller: opcodes, FSM states,
// datapath mux selects and the control-word bundle.
package mc_main_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_MEMADR  = 4'd3,
    ST_MEMRD   = 4'd4,
    ST_MEMWB   = 4'd5,
    ST_MEMWR   = 4'd6,
    ST_RTYPEEX = 4'd7,
    ST_RTYPEWB = 4'd8,
    ST_BEQEX   = 4'd9,
    ST_ADDIEX  = 4'd10,
    ST_ADDIWB  = 4'd11,
    ST_JEX     = 4'd12
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;

  // States that own the unified memory port and wait on its ready.
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive not-ready memory cycles; expire_c flags the cycle on
// which the count would reach WAIT_MAX (never when WAIT_MAX is 0).
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned   CW      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST    = CW'(WAIT_MAX - 1);
  localparam bit            ENABLED = (WAIT_MAX != 0);

  logic [CW-1:0] cnt_q;

  assign expire_c = ENABLED && en && (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr || expire_c) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main-control FSM: sequences PC/IR/ALU/memory/regfile per
// instruction, with a memory wait-timeout guard and a retired-instruction count.
module mc_main_ctrl
  import mc_main_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [5:0]       op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             iord_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic             irwrite_o,
  output logic             pcwrite_o,
  output logic [1:0]       pcsrc_o,
  output logic             alusrca_o,
  output logic [1:0]       alusrcb_o,
  output logic [1:0]       aluop_o,
  output logic             regdst_o,
  output logic             memtoreg_o,
  output logic             regwrite_o,
  output logic             illegal_o,
  output logic             memerr_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [3:0]       state_o
);

  state_e           state_q, state_d;
  ctrl_t            ctrl;
  logic             illegal_c, retire_c, wait_en_c, expire_c;
  logic [CNT_W-1:0] retired_q;

  assign wait_en_c = is_mem_state(state_q) && !mem_ready_i;

  mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr      (~wait_en_c),
    .en       (wait_en_c),
    .expire_c (expire_c)
  );

  // Next state and control word; handshake-gated writes are Mealy on the inputs.
  always_comb begin
    state_d   = state_q;
    ctrl      = '0;
    illegal_c = 1'b0;
    retire_c  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = mem_ready_i;
        ctrl.pcwrite = mem_ready_i;
        if (mem_ready_i)   state_d = ST_DECODE;
        else if (expire_c) state_d = ST_FETCH;
      end
      ST_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
        case (op_i)
          OP_LB, OP_SB: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTYPEEX;
          OP_BEQ:       state_d = ST_BEQEX;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JEX;
          default: begin
            illegal_c = 1'b1;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
        state_d      = (op_i == OP_SB) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.memread = 1'b1;
        if (mem_ready_i)   state_d = ST_MEMWB;
        else if (expire_c) state_d = ST_FETCH;
      end
      ST_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        retire_c      = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        retire_c      = mem_ready_i;
        if (mem_ready_i || expire_c) state_d = ST_FETCH;
      end
      ST_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALUOP_FUNCT;
        state_d      = ST_RTYPEWB;
      end
      ST_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        retire_c      = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.pcwrite = zero_i;
        retire_c     = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
        state_d      = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        ctrl.regwrite = 1'b1;
        retire_c      = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
        retire_c     = 1'b1;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign iord_o     = ctrl.iord;
  assign memread_o  = ctrl.memread;
  assign memwrite_o = ctrl.memwrite;
  assign irwrite_o  = ctrl.irwrite;
  assign pcwrite_o  = ctrl.pcwrite;
  assign pcsrc_o    = ctrl.pcsrc;
  assign alusrca_o  = ctrl.alusrca;
  assign alusrcb_o  = ctrl.alusrcb;
  assign aluop_o    = ctrl.aluop;
  assign regdst_o   = ctrl.regdst;
  assign memtoreg_o = ctrl.memtoreg;
  assign regwrite_o = ctrl.regwrite;
  assign illegal_o  = illegal_c;
  assign memerr_o   = expire_c;
  assign retired_o  = retired_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: an instruction-level model queues the
// expected control vector per cycle; a negedge monitor pops and compares.
module tb_mc_main_ctrl;
  import mc_main_ctrl_pkg::*;

  localparam int unsigned WMAX = 4;
  localparam int unsigned CW   = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [5:0]    op_i = '0;
  logic          zero_i = 1'b0;
  logic          mem_ready_i = 1'b0;
  logic          iord_o, memread_o, memwrite_o, irwrite_o, pcwrite_o;
  logic [1:0]    pcsrc_o, alusrcb_o, aluop_o;
  logic          alusrca_o, regdst_o, memtoreg_o, regwrite_o, illegal_o, memerr_o;
  logic [CW-1:0] retired_o;
  logic [3:0]    state_o;

  mc_main_ctrl #(.WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .op_i(op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .iord_o(iord_o), .memread_o(memread_o),
    .memwrite_o(memwrite_o), .irwrite_o(irwrite_o), .pcwrite_o(pcwrite_o),
    .pcsrc_o(pcsrc_o), .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o),
    .aluop_o(aluop_o), .regdst_o(regdst_o), .memtoreg_o(memtoreg_o),
    .regwrite_o(regwrite_o), .illegal_o(illegal_o), .memerr_o(memerr_o),
    .retired_o(retired_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]    st;
    logic          iord, memread, memwrite, irwrite, pcwrite;
    logic [1:0]    pcsrc;
    logic          alusrca;
    logic [1:0]    alusrcb, aluop;
    logic          regdst, memtoreg, regwrite, illegal, memerr;
    logic [CW-1:0] retired;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ret   = 0;
  int   cyc   = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic obs_t base(input state_e s);
    obs_t o = '0;
    o.st      = s;
    o.retired = CW'(ret);
    return o;
  endfunction

  // Instruction class from the opcode table: 0 illegal, 1 R, 2 LB, 3 SB, 4 BEQ, 5 ADDI, 6 J.
  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000: return 1;
      6'b100000: return 2;
      6'b101000: return 3;
      6'b000100: return 4;
      6'b001000: return 5;
      6'b000010: return 6;
      default:   return 0;
    endcase
  endfunction

  always @(negedge clk_i) begin : monitor
    obs_t a, e;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.st = state_o;       a.iord = iord_o;         a.memread = memread_o;
      a.memwrite = memwrite_o; a.irwrite = irwrite_o; a.pcwrite = pcwrite_o;
      a.pcsrc = pcsrc_o;    a.alusrca = alusrca_o;   a.alusrcb = alusrcb_o;
      a.aluop = aluop_o;    a.regdst = regdst_o;     a.memtoreg = memtoreg_o;
      a.regwrite = regwrite_o; a.illegal = illegal_o; a.memerr = memerr_o;
      a.retired = retired_o;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle %0d ctrl_vector: got %h expected %h (state got %0d expected %0d, retired got %0d expected %0d)",
                 cyc, a, e, a.st, e.st, a.retired, e.retired);
      end
    end
  end

  task automatic step(input obs_t e, input logic rdy, input logic z, input logic [5:0] op);
    op_i = op; zero_i = z; mem_ready_i = rdy;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
  endtask

  task automatic bump();
    ret = (ret + 1) % (1 << CW);
  endtask

  // Fetch with w not-ready cycles; every WMAX-th consecutive wait aborts and refetches.
  task automatic fetch(input int w);
    int   k = 0;
    obs_t e;
    for (int i = 0; i < w; i++) begin
      k++;
      e = base(ST_FETCH); e.memread = 1'b1; e.alusrcb = 2'b01;
      e.memerr = (k == WMAX);
      step(e, 1'b0, rb(), r6());
      if (k == WMAX) k = 0;
    end
    e = base(ST_FETCH); e.memread = 1'b1; e.alusrcb = 2'b01;
    e.irwrite = 1'b1; e.pcwrite = 1'b1;
    step(e, 1'b1, rb(), r6());
  endtask

  task automatic exec(input logic [5:0] op, input logic z, input int wf, input int wm);
    obs_t   e;
    int     kind, n;
    state_e ms;
    kind = kind_of(op);
    fetch(wf);
    e = base(ST_DECODE); e.alusrcb = 2'b11;
    e.illegal = (kind == 0);
    step(e, rb(), rb(), op);
    case (kind)
      1: begin
        e = base(ST_RTYPEEX); e.alusrca = 1'b1; e.aluop = 2'b10;
        step(e, rb(), rb(), op);
        e = base(ST_RTYPEWB); e.regdst = 1'b1; e.regwrite = 1'b1;
        step(e, rb(), rb(), op); bump();
      end
      2, 3: begin
        e = base(ST_MEMADR); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(e, rb(), rb(), op);
        ms = (kind == 2) ? ST_MEMRD : ST_MEMWR;
        n  = (wm >= WMAX) ? WMAX : wm;
        for (int i = 0; i < n; i++) begin
          e = base(ms); e.iord = 1'b1;
          e.memread = (kind == 2); e.memwrite = (kind == 3);
          e.memerr = (i == WMAX - 1);
          step(e, 1'b0, rb(), op);
        end
        if (wm < WMAX) begin
          e = base(ms); e.iord = 1'b1;
          e.memread = (kind == 2); e.memwrite = (kind == 3);
          step(e, 1'b1, rb(), op);
          if (kind == 3) bump();
          else begin
            e = base(ST_MEMWB); e.memtoreg = 1'b1; e.regwrite = 1'b1;
            step(e, rb(), rb(), op); bump();
          end
        end
      end
      4: begin
        e = base(ST_BEQEX); e.alusrca = 1'b1; e.aluop = 2'b01;
        e.pcsrc = 2'b01; e.pcwrite = z;
        step(e, rb(), z, op); bump();
      end
      5: begin
        e = base(ST_ADDIEX); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(e, rb(), rb(), op);
        e = base(ST_ADDIWB); e.regwrite = 1'b1;
        step(e, rb(), rb(), op); bump();
      end
      6: begin
        e = base(ST_JEX); e.pcsrc = 2'b10; e.pcwrite = 1'b1;
        step(e, rb(), rb(), op); bump();
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    obs_t e;
    rst_n_i = 1'b0; ret = 0;
    op_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
    e = base(ST_IDLE);
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    step(base(ST_IDLE), rb(), rb(), r6());
  endtask

  // Reset lands asynchronously in the middle of an LB's MEMRD cycle.
  task automatic reset_in_memrd();
    obs_t e;
    fetch(0);
    e = base(ST_DECODE); e.alusrcb = 2'b11;
    step(e, rb(), rb(), 6'b100000);
    e = base(ST_MEMADR); e.alusrca = 1'b1; e.alusrcb = 2'b10;
    step(e, rb(), rb(), 6'b100000);
    mem_ready_i = 1'b0;
    #1;
    rst_n_i = 1'b0; ret = 0;
    exp_q.push_back(base(ST_IDLE));
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    step(base(ST_IDLE), rb(), rb(), r6());
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 8))
      0: return 6'b000000;
      1: return 6'b100000;
      2: return 6'b101000;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      6: return 6'b111111;
      default: return r6();
    endcase
  endfunction

  initial begin
    @(posedge clk_i); #1;
    do_reset();
    exec(6'b000000, 1'b0, 0, 0);
    exec(6'b100000, 1'b0, 0, 3);
    exec(6'b000100, 1'b1, 0, 0);
    exec(6'b000100, 1'b0, 0, 0);
    exec(6'b111111, 1'b0, 0, 0);
    exec(6'b101000, 1'b0, 0, 4);
    exec(6'b101000, 1'b0, 0, 3);
    exec(6'b100000, 1'b0, 0, 6);
    exec(6'b001000, 1'b0, 5, 0);
    exec(6'b000010, 1'b0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      exec(rand_op(), rb(),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 0,
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : 0);
    end
    reset_in_memrd();
    for (int i = 0; i < 20; i++) exec(rand_op(), rb(), 0, int'($urandom_range(0, 2)));
    @(negedge clk_i); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
